vga_rect_draw_unit: RTL and testbench

- Single-clock successor to the draw unit: a VGA timing generator plus a rectangle-overlay compositor.
- Draw commands arrive through a write-enable/full command port into an internal FIFO.
- Commands are applied to a bank of rectangle slots only during vertical blanking, so no tearing.
- Each active pixel gets the colour of the highest-priority slot that covers it, otherwise the background colour.

---
 rtl/draw_pkg.sv | 60 ++++++
 rtl/draw_cmd_fifo.sv | 53 +++++
 rtl/vga_rect_draw_unit.sv | 197 +++++++++++++++++++
 tb/tb_vga_rect_draw_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared definitions for the rectangle draw unit: default 640x480@60 timing,
// command word layout helpers and the loader state encoding.
package draw_pkg;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_X_W        = 10;
  localparam int DEF_Y_W        = 10;
  localparam int DEF_COLOR_W    = 3;
  localparam int DEF_N_RECT     = 4;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum int {
    F_COLOR,
    F_Y1,
    F_X1,
    F_Y0,
    F_X0,
    F_SLOT,
    F_EN
  } cmd_field_e;

  typedef enum logic [0:0] {
    LD_IDLE = 1'b0,
    LD_LOAD = 1'b1
  } ld_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Command word is {en, slot, x0, y0, x1, y1, color}, MSB first.
  function automatic int cmd_lsb(input cmd_field_e f, input int sw, input int xw,
                                 input int yw, input int cw);
    case (f)
      F_COLOR: return 0;
      F_Y1:    return cw;
      F_X1:    return cw + yw;
      F_Y0:    return cw + yw + xw;
      F_X0:    return cw + 2*yw + xw;
      F_SLOT:  return cw + 2*yw + 2*xw;
      F_EN:    return cw + 2*yw + 2*xw + sw;
      default: return 0;
    endcase
  endfunction

  function automatic int cmd_width(input int sw, input int xw, input int yw, input int cw);
    return 1 + sw + 2*xw + 2*yw + cw;
  endfunction

endpackage

// File: rtl/draw_cmd_fifo.sv
// Synchronous show-ahead FIFO holding draw commands until vertical blanking.
module draw_cmd_fifo
  import draw_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = we && !full;
  assign pop   = re && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vga_rect_draw_unit.sv
// VGA timing generator with a bank of prioritised rectangle overlays; slot
// updates queue in a FIFO and are applied only during vertical blanking.
module vga_rect_draw_unit
  import draw_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit SYNC_POL   = 1'b0,
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int BG_COLOR   = 0,
  parameter int N_RECT     = DEF_N_RECT,
  parameter int SLOT_W     = clog2(N_RECT),
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CMD_W      = cmd_width(SLOT_W, X_W, Y_W, COLOR_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [CMD_W-1:0]   data,
  output logic               full,
  output logic               overflow,
  output logic [COLOR_W-1:0] color,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [X_W-1:0]     H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0]     H_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0]     H_SS     = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0]     H_SE     = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0]     V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0]     V_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0]     V_SS     = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0]     V_SE     = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COLOR_W-1:0] BG       = COLOR_W'(BG_COLOR);

  localparam int OFF_COLOR = cmd_lsb(F_COLOR, SLOT_W, X_W, Y_W, COLOR_W);
  localparam int OFF_Y1    = cmd_lsb(F_Y1,    SLOT_W, X_W, Y_W, COLOR_W);
  localparam int OFF_X1    = cmd_lsb(F_X1,    SLOT_W, X_W, Y_W, COLOR_W);
  localparam int OFF_Y0    = cmd_lsb(F_Y0,    SLOT_W, X_W, Y_W, COLOR_W);
  localparam int OFF_X0    = cmd_lsb(F_X0,    SLOT_W, X_W, Y_W, COLOR_W);
  localparam int OFF_SLOT  = cmd_lsb(F_SLOT,  SLOT_W, X_W, Y_W, COLOR_W);
  localparam int OFF_EN    = cmd_lsb(F_EN,    SLOT_W, X_W, Y_W, COLOR_W);

  logic [DIV_W-1:0]   div_q;
  logic               pe;
  logic [X_W-1:0]     h_p0;
  logic [Y_W-1:0]     v_p0;
  logic               vblank;

  logic               active_p0;
  logic               hsync_p0;
  logic               vsync_p0;
  logic [COLOR_W-1:0] hit_color;
  logic [COLOR_W-1:0] color_p0;

  logic [N_RECT-1:0]  slot_en;
  logic [X_W-1:0]     slot_x0 [N_RECT];
  logic [X_W-1:0]     slot_x1 [N_RECT];
  logic [Y_W-1:0]     slot_y0 [N_RECT];
  logic [Y_W-1:0]     slot_y1 [N_RECT];
  logic [COLOR_W-1:0] slot_col [N_RECT];

  ld_state_e          ld_state;
  logic               fifo_empty;
  logic               fifo_re;
  logic [CMD_W-1:0]   cmd;
  logic               cmd_en;
  logic [SLOT_W-1:0]  cmd_slot;

  // Stage p0: pixel divider and raster counters
  assign pe     = (div_q == DIV_LAST);
  assign vblank = (v_p0 >= V_ACT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      h_p0  <= '0;
      v_p0  <= '0;
    end else begin
      div_q <= pe ? '0 : div_q + 1'b1;
      if (pe) begin
        if (h_p0 == H_LAST) begin
          h_p0 <= '0;
          v_p0 <= (v_p0 == V_LAST) ? '0 : v_p0 + 1'b1;
        end else begin
          h_p0 <= h_p0 + 1'b1;
        end
      end
    end
  end

  assign active_p0 = (h_p0 < H_ACT) && (v_p0 < V_ACT);
  assign hsync_p0  = (h_p0 >= H_SS && h_p0 < H_SE) ? SYNC_POL : ~SYNC_POL;
  assign vsync_p0  = (v_p0 >= V_SS && v_p0 < V_SE) ? SYNC_POL : ~SYNC_POL;

  // Walk from the highest slot down so the lowest matching index wins.
  always_comb begin
    hit_color = BG;
    for (int i = N_RECT - 1; i >= 0; i--) begin
      if (slot_en[i] &&
          slot_x0[i] <= h_p0 && h_p0 <= slot_x1[i] &&
          slot_y0[i] <= v_p0 && v_p0 <= slot_y1[i]) begin
        hit_color = slot_col[i];
      end
    end
  end

  assign color_p0 = active_p0 ? hit_color : '0;

  // Stage p1: registered video outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color       <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pe && (h_p0 == '0) && (v_p0 == '0);
      if (pe) begin
        color  <= color_p0;
        hsync  <= hsync_p0;
        vsync  <= vsync_p0;
        active <= active_p0;
      end
    end
  end

  draw_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .re    (fifo_re),
    .din   (data),
    .dout  (cmd),
    .full  (full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (we && full) overflow <= 1'b1;
  end

  // Pops run at clk rate, independent of pe, so a full FIFO drains early in vblank.
  assign fifo_re  = (ld_state == LD_LOAD) && vblank && !fifo_empty;
  assign cmd_en   = cmd[OFF_EN];
  assign cmd_slot = cmd[OFF_SLOT +: SLOT_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_state <= LD_IDLE;
    end else begin
      case (ld_state)
        LD_IDLE: if (vblank && !fifo_empty) ld_state <= LD_LOAD;
        LD_LOAD: if (!vblank || fifo_empty) ld_state <= LD_IDLE;
        default: ld_state <= LD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) slot_en <= '0;
    else if (fifo_re) slot_en[cmd_slot] <= cmd_en;
  end

  always_ff @(posedge clk) begin
    if (fifo_re) begin
      slot_x0[cmd_slot]  <= cmd[OFF_X0 +: X_W];
      slot_y0[cmd_slot]  <= cmd[OFF_Y0 +: Y_W];
      slot_x1[cmd_slot]  <= cmd[OFF_X1 +: X_W];
      slot_y1[cmd_slot]  <= cmd[OFF_Y1 +: Y_W];
      slot_col[cmd_slot] <= cmd[OFF_COLOR +: COLOR_W];
    end
  end

endmodule

// File: tb/tb_vga_rect_draw_unit.sv
// Scoreboard bench for vga_rect_draw_unit using a shrunken 56x38 raster so
// several frames fit in a short run.
module tb_vga_rect_draw_unit;

  localparam int XW   = 10;
  localparam int YW   = 10;
  localparam int CW   = 3;
  localparam int SW   = 2;
  localparam int CMDW = 1 + SW + 2*XW + 2*YW + CW;
  localparam int HT   = 56;
  localparam int VT   = 38;
  localparam int FPIX = HT * VT;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          we = 1'b0;
  logic [CMDW-1:0] data = '0;
  logic          full, overflow, hsync, vsync, active, frame_start;
  logic [CW-1:0] color;

  vga_rect_draw_unit #(
    .CLK_DIV(2), .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(4), .SYNC_POL(1'b0),
    .X_W(XW), .Y_W(YW), .COLOR_W(CW), .BG_COLOR(1), .N_RECT(4), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .data(data), .full(full),
    .overflow(overflow), .color(color), .hsync(hsync), .vsync(vsync),
    .active(active), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef enum int {K_COLOR, K_HS, K_VS, K_ACT, K_FS, K_FULL, K_OVF} kind_e;
  typedef struct {
    int    c;
    kind_e k;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  exp_t mon_e;

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void expect_at(input int c, input kind_e k, input int e, input string name);
    exp_t n;
    int   i;
    n.c = c; n.k = k; n.exp = e; n.name = name;
    i = 0;
    while (i < sb.size() && sb[i].c <= c) i++;
    sb.insert(i, n);
  endfunction

  function automatic int pc(input int f, input int h, input int v);
    return 2 * (f*FPIX + v*HT + h + 1);
  endfunction

  function automatic void px(input int f, input int h, input int v, input int col);
    expect_at(pc(f, h, v), K_COLOR, col, $sformatf("color f%0d (%0d,%0d)", f, h, v));
  endfunction

  function automatic int sample(input kind_e k);
    case (k)
      K_COLOR: return int'(color);
      K_HS:    return int'(hsync);
      K_VS:    return int'(vsync);
      K_ACT:   return int'(active);
      K_FS:    return int'(frame_start);
      K_FULL:  return int'(full);
      K_OVF:   return int'(overflow);
      default: return -1;
    endcase
  endfunction

  function automatic logic [CMDW-1:0] mk(input int en, input int slot, input int x0, input int y0,
                                         input int x1, input int y1, input int col);
    logic [CMDW-1:0] r;
    r = {1'(en), 2'(slot), 10'(x0), 10'(y0), 10'(x1), 10'(y1), 3'(col)};
    return r;
  endfunction

  // Monitor: pops every expectation whose clk has come and compares it.
  always @(negedge clk) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].c <= cyc) begin
        mon_e = sb.pop_front();
        if (mon_e.c < cyc) begin
          tests++;
          fails++;
          $display("FAIL %s: missed at clk %0d, required %0d", mon_e.name, mon_e.c, mon_e.exp);
        end else begin
          chk(mon_e.name, sample(mon_e.k), mon_e.exp);
        end
      end
    end
  end

  task automatic send(input logic [CMDW-1:0] d);
    we   = 1'b1;
    data = d;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int c0;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Pre-reset activity: load a full-screen slot, overflow the FIFO, queue another command.
    wait_cyc(100);
    repeat (9) send(mk(1, 0, 0, 0, 1023, 1023, 5));
    expect_at(110, K_FULL, 1, "pre full");
    expect_at(112, K_OVF, 1, "pre overflow");
    px(1, 5, 5, 5);
    wait_cyc(pc(1, 0, 3));
    send(mk(1, 1, 0, 0, 1023, 1023, 6));
    wait_cyc(pc(1, 0, 10));

    reset = 1'b1;
    #1;
    chk("rst color", int'(color), 0);
    chk("rst hsync", int'(hsync), 1);
    chk("rst vsync", int'(vsync), 1);
    chk("rst full", int'(full), 0);
    chk("rst overflow", int'(overflow), 0);
    chk("rst active", int'(active), 0);
    chk("rst frame_start", int'(frame_start), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Frame-0 raster timing and frame_start cadence
    expect_at(2, K_FS, 1, "fs first");
    expect_at(3, K_FS, 0, "fs width");
    expect_at(pc(1, 0, 0) - 1, K_FS, 0, "fs before f1");
    expect_at(pc(1, 0, 0), K_FS, 1, "fs f1");
    expect_at(pc(3, 0, 0), K_FS, 1, "fs f3");
    expect_at(pc(0, 43, 0), K_HS, 1, "hs h43");
    expect_at(pc(0, 44, 0), K_HS, 0, "hs h44");
    expect_at(pc(0, 44, 0) + 1, K_HS, 0, "hs h44 odd");
    expect_at(pc(0, 51, 0), K_HS, 0, "hs h51");
    expect_at(pc(0, 52, 0), K_HS, 1, "hs h52");
    expect_at(pc(0, 44, 1), K_HS, 0, "hs line1");
    expect_at(pc(0, 55, 31), K_VS, 1, "vs v31");
    expect_at(pc(0, 0, 32), K_VS, 0, "vs v32");
    expect_at(pc(0, 55, 33), K_VS, 0, "vs v33");
    expect_at(pc(0, 0, 34), K_VS, 1, "vs v34");
    expect_at(pc(0, 39, 0), K_ACT, 1, "act h39");
    expect_at(pc(0, 40, 0), K_ACT, 0, "act h40");
    expect_at(pc(0, 39, 29), K_ACT, 1, "act v29");
    expect_at(pc(0, 0, 30), K_ACT, 0, "act v30");
    px(0, 0, 0, 1);
    px(0, 45, 5, 0);

    // Overflow burst on line 10; the 9th write must be dropped.
    wait_cyc(pc(0, 0, 10));
    c0 = cyc;
    expect_at(c0 + 7, K_FULL, 0, "full after 7");
    expect_at(c0 + 8, K_FULL, 1, "full after 8");
    expect_at(c0 + 8, K_OVF, 0, "ovf before drop");
    expect_at(c0 + 9, K_OVF, 1, "ovf after drop");
    expect_at(2*30*HT + 1, K_FULL, 1, "full vblank entry");
    expect_at(2*30*HT + 2, K_FULL, 0, "full after first pop");
    expect_at(2*30*HT + 40, K_OVF, 1, "ovf sticky");
    px(1, 0, 0, 1);
    px(1, 25, 8, 1);
    px(1, 10, 5, 4);
    px(1, 19, 14, 4);
    px(1, 9, 5, 1);
    px(1, 20, 5, 1);
    px(1, 10, 15, 1);
    px(1, 1, 1, 1);
    px(1, 29, 10, 1);
    px(1, 30, 10, 1);
    px(1, 3, 24, 1);
    px(1, 3, 25, 1);
    px(1, 45, 5, 0);
    send(mk(1, 3, 10, 5, 19, 14, 7));
    send(mk(1, 2, 1, 1, 2, 2, 5));
    send(mk(1, 2, 30, 0, 29, 29, 6));
    send(mk(1, 1, 0, 25, 5, 24, 5));
    send(mk(0, 0, 0, 0, 39, 29, 7));
    send(mk(1, 3, 10, 5, 19, 14, 2));
    send(mk(1, 3, 10, 5, 19, 14, 3));
    send(mk(1, 3, 10, 5, 19, 14, 4));
    send(mk(1, 3, 10, 5, 19, 14, 6));

    // Priority and boundary rectangles, visible from frame 2.
    wait_cyc(pc(1, 0, 10));
    px(2, 7, 7, 2);
    px(2, 3, 3, 2);
    px(2, 15, 15, 3);
    px(2, 12, 8, 3);
    px(2, 19, 14, 3);
    px(2, 25, 8, 1);
    px(2, 35, 25, 7);
    px(2, 39, 29, 7);
    px(2, 34, 25, 1);
    px(2, 35, 24, 1);
    px(2, 40, 29, 0);
    px(2, 39, 30, 0);
    send(mk(1, 0, 0, 0, 9, 9, 2));
    send(mk(1, 1, 5, 5, 20, 20, 3));
    send(mk(1, 2, 35, 25, 1023, 1023, 7));

    // Disable slot 0; slot 1 takes over the overlap in frame 3.
    wait_cyc(pc(2, 0, 10));
    px(3, 7, 7, 3);
    px(3, 3, 3, 1);
    px(3, 15, 15, 3);
    px(3, 35, 25, 7);
    send(mk(0, 0, 0, 0, 9, 9, 2));

    wait_cyc(pc(3, 55, 37) + 4);
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: never sampled, required %0d", mon_e.name, mon_e.exp);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
